dc_video_capture: RTL and testbench

Captures the Dreamcast's 24-bit digital pixel stream into the line-buffer RAM that the output scan stage reads. It recovers pixel and line position from the incoming hsync/vsync, writes the visible window as consecutive `BUFFER_LINE_LENGTH`-word lines, and issues `starttrigger` once enough lines are buffered. It sits directly upstream of the RAM-to-video stage.

---
 rtl/dc_video_capture.sv | 151 +++++++++++++++
 tb/tb_dc_video_capture.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dc_video_capture.sv
// Dreamcast 24-bit pixel capture: recovers pixel/line position from the syncs,
// writes the visible window into the line-buffer RAM and kicks the reader.
module dc_video_capture #(
  parameter int BUFFER_LINE_LENGTH = 640,
  parameter int RAM_NUMWORDS       = 10240,
  parameter int RAM_ADDRESS_BITS   = 14,
  parameter int H_CAPTURE_START    = 144,
  parameter int V_CAPTURE_START    = 35,
  parameter int V_CAPTURE_LINES    = 480,
  parameter int TRIGGER_LINE       = 8
) (
  input  logic                        clock_i,
  input  logic                        reset_n_i,
  input  logic [23:0]                 indata_i,
  input  logic                        hsync_i,
  input  logic                        vsync_i,
  output logic [RAM_ADDRESS_BITS-1:0] wraddr_o,
  output logic [23:0]                 wrdata_o,
  output logic                        wren_o,
  output logic                        starttrigger_o,
  output logic                        locked_o
);

  localparam int AW = RAM_ADDRESS_BITS;

  localparam logic [11:0]   H_LO      = 12'(H_CAPTURE_START);
  localparam logic [11:0]   H_HI      = 12'(H_CAPTURE_START + BUFFER_LINE_LENGTH);
  localparam logic [10:0]   V_LO      = 11'(V_CAPTURE_START);
  localparam logic [10:0]   V_HI      = 11'(V_CAPTURE_START + V_CAPTURE_LINES);
  localparam logic [10:0]   TRIG_Y    = 11'(V_CAPTURE_START + TRIGGER_LINE);
  localparam logic [AW-1:0] LLEN      = AW'(BUFFER_LINE_LENGTH);
  localparam logic [AW-1:0] BASE_LAST = AW'(RAM_NUMWORDS - BUFFER_LINE_LENGTH);

  typedef enum logic [1:0] {WAIT_VSYNC, WAIT_HSYNC, FRAME} state_e;

  state_e          state_q, state_d;
  logic            hs_q, hs_prev_q, vs_q, vs_prev_q;
  logic [11:0]     cnt_x_q, cnt_x_d;
  logic [10:0]     cnt_y_q, cnt_y_d;
  logic [AW-1:0]   line_base_q, line_base_d;
  logic            frame_pending_q, frame_pending_d;
  logic            wren_q, wren_d;
  logic [AW-1:0]   wraddr_q, wraddr_d;
  logic [23:0]     wrdata_q, wrdata_d;
  logic            trig_q, trig_d;

  logic            hs_fall, vs_fall;
  logic            in_x, in_y, in_win;
  logic [9:0]      x_off;

  // Two flops per sync: edge is seen one cycle after the pin moves.
  assign hs_fall = hs_prev_q & ~hs_q;
  assign vs_fall = vs_prev_q & ~vs_q;

  assign in_x   = (cnt_x_q >= H_LO) && (cnt_x_q < H_HI);
  assign in_y   = (cnt_y_q >= V_LO) && (cnt_y_q < V_HI);
  assign in_win = (state_q == FRAME) && in_x && in_y;
  assign x_off  = cnt_x_q[9:0] - H_LO[9:0];

  always_comb begin
    state_d         = state_q;
    cnt_x_d         = cnt_x_q;
    cnt_y_d         = cnt_y_q;
    line_base_d     = line_base_q;
    frame_pending_d = frame_pending_q;
    wren_d          = 1'b0;
    wraddr_d        = wraddr_q;
    wrdata_d        = wrdata_q;
    trig_d          = 1'b0;
    case (state_q)
      WAIT_VSYNC: begin
        if (vs_fall) state_d = WAIT_HSYNC;
      end
      WAIT_HSYNC: begin
        if (hs_fall) begin
          state_d         = FRAME;
          cnt_x_d         = '0;
          cnt_y_d         = '0;
          line_base_d     = '0;
          frame_pending_d = 1'b0;
        end
      end
      FRAME: begin
        if (in_win) begin
          wren_d   = 1'b1;
          wraddr_d = line_base_q + {{(AW-10){1'b0}}, x_off};
          wrdata_d = indata_i;
        end
        if (cnt_x_q == '1) begin
          // No hsync for a whole counter span: the source is gone.
          state_d         = WAIT_VSYNC;
          frame_pending_d = 1'b0;
        end else if (hs_fall) begin
          cnt_x_d = '0;
          if (in_y && (cnt_y_q == TRIG_Y)) trig_d = 1'b1;
          if (frame_pending_q || vs_fall) begin
            cnt_y_d         = '0;
            line_base_d     = '0;
            frame_pending_d = 1'b0;
          end else begin
            if (cnt_y_q != '1) cnt_y_d = cnt_y_q + 11'd1;
            if (in_y) line_base_d = (line_base_q < BASE_LAST) ? line_base_q + LLEN : '0;
          end
        end else begin
          cnt_x_d = cnt_x_q + 12'd1;
          if (vs_fall) frame_pending_d = 1'b1;
        end
      end
      default: state_d = WAIT_VSYNC;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q         <= WAIT_VSYNC;
      hs_q            <= 1'b0;
      hs_prev_q       <= 1'b0;
      vs_q            <= 1'b0;
      vs_prev_q       <= 1'b0;
      cnt_x_q         <= '0;
      cnt_y_q         <= '0;
      line_base_q     <= '0;
      frame_pending_q <= 1'b0;
      wren_q          <= 1'b0;
      wraddr_q        <= '0;
      wrdata_q        <= '0;
      trig_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      hs_q            <= hsync_i;
      hs_prev_q       <= hs_q;
      vs_q            <= vsync_i;
      vs_prev_q       <= vs_q;
      cnt_x_q         <= cnt_x_d;
      cnt_y_q         <= cnt_y_d;
      line_base_q     <= line_base_d;
      frame_pending_q <= frame_pending_d;
      wren_q          <= wren_d;
      wraddr_q        <= wraddr_d;
      wrdata_q        <= wrdata_d;
      trig_q          <= trig_d;
    end
  end

  assign wraddr_o       = wraddr_q;
  assign wrdata_o       = wrdata_q;
  assign wren_o         = wren_q;
  assign starttrigger_o = trig_q;
  assign locked_o       = (state_q == FRAME);

endmodule

// File: tb/tb_dc_video_capture.sv
// Bench for dc_video_capture: directed vector table, randomized frames against a
// line/pixel scoreboard, and hand sequences for lost sync and async reset.
module tb_dc_video_capture;
  localparam int BLL = 4, RAMW = 12, AW = 14, HS = 2, VS = 0, VL = 5, TL = 2, NF = 5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [23:0]   indata = '0;
  logic          hsync = 1'b1, vsync = 1'b1;
  logic [AW-1:0] wraddr;
  logic [23:0]   wrdata;
  logic          wren, trig, locked;

  dc_video_capture #(
    .BUFFER_LINE_LENGTH(BLL), .RAM_NUMWORDS(RAMW), .RAM_ADDRESS_BITS(AW),
    .H_CAPTURE_START(HS), .V_CAPTURE_START(VS), .V_CAPTURE_LINES(VL), .TRIGGER_LINE(TL)
  ) dut (
    .clock_i(clock), .reset_n_i(reset_n), .indata_i(indata), .hsync_i(hsync), .vsync_i(vsync),
    .wraddr_o(wraddr), .wrdata_o(wrdata), .wren_o(wren), .starttrigger_o(trig), .locked_o(locked)
  );

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  int stamp = 0, ph0 = 0;
  bit rec = 0;

  typedef struct { int t; logic [AW-1:0] a; logic [23:0] d; } wr_t;
  wr_t got_wr[$], exp_wr[$];
  int  got_tr[$], exp_tr[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Inputs change 1ns after an edge; outputs are sampled 1ns after the next edge.
  task automatic tick(input logic h, input logic v, input logic [23:0] d);
    wr_t w;
    hsync = h; vsync = v; indata = d;
    @(posedge clock); #1;
    if (rec) begin
      if (wren) begin w.t = stamp - ph0; w.a = wraddr; w.d = wrdata; got_wr.push_back(w); end
      if (trig) got_tr.push_back(stamp - ph0);
    end
    stamp++;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_wren"}, 64'(wren), 64'd0);
    chk({nm, "_wraddr"}, 64'(wraddr), 64'd0);
    chk({nm, "_wrdata"}, 64'(wrdata), 64'd0);
    chk({nm, "_trig"}, 64'(trig), 64'd0);
    chk({nm, "_locked"}, 64'(locked), 64'd0);
  endtask

  typedef struct { logic hs; logic vs; logic [23:0] d; logic ew; logic [AW-1:0] ea; logic [23:0] ed; logic el; } vec_t;
  vec_t tbl[13];

  logic        sh[$], sv[$];
  logic [23:0] sd[$];
  int          ln_n[$], ln_y[$], ln_l[$];
  bit          coin[NF];

  initial begin
    int drop, wcnt, n_tail;
    logic [23:0] dd;

    // Single captured line: vsync fall, hsync fall, pixels A0..A7.
    for (int i = 0; i < 13; i++) begin
      tbl[i].hs = 1; tbl[i].vs = 1; tbl[i].d = 24'h55;
      tbl[i].ew = 0; tbl[i].ea = '0; tbl[i].ed = '0; tbl[i].el = (i >= 4);
    end
    tbl[1].vs = 0; tbl[3].hs = 0; tbl[4].d = 24'h99;
    for (int k = 0; k < 8; k++) tbl[5+k].d = 24'hA0 + 24'(k);
    for (int k = 0; k < 4; k++) begin
      tbl[7+k].ew = 1; tbl[7+k].ea = AW'(k); tbl[7+k].ed = 24'hA2 + 24'(k);
    end
    for (int i = 11; i < 13; i++) begin tbl[i].ea = AW'(3); tbl[i].ed = 24'hA5; end

    repeat (3) @(posedge clock);
    #1 chk_reset("por");
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].hs, tbl[i].vs, tbl[i].d);
      chk($sformatf("t1_wren[%0d]", i), 64'(wren), 64'(tbl[i].ew));
      chk($sformatf("t1_addr[%0d]", i), 64'(wraddr), 64'(tbl[i].ea));
      chk($sformatf("t1_data[%0d]", i), 64'(wrdata), 64'(tbl[i].ed));
      chk($sformatf("t1_lock[%0d]", i), 64'(locked), 64'(tbl[i].el));
    end

    reset_n = 1'b0; #1 chk_reset("rst2");
    @(posedge clock); #1 reset_n = 1'b1;

    // Randomized frames: some start with vsync during the last line, some with
    // vsync and hsync falling together.
    coin[0] = 0;
    for (int f = 1; f < NF; f++) coin[f] = bit'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) begin sh.push_back(1); sv.push_back(1); sd.push_back(24'($urandom())); end
    for (int i = 0; i < 4; i++) begin sh.push_back(1); sv.push_back(i != 0); sd.push_back(24'($urandom())); end
    for (int f = 0; f < NF; f++) begin
      int nl;
      nl = $urandom_range(6, 8);
      for (int y = 0; y < nl; y++) begin
        int L, pw, n;
        L = $urandom_range(7, 11); pw = $urandom_range(1, 2); n = sh.size();
        for (int j = 0; j < L; j++) begin
          sh.push_back(j >= pw);
          sv.push_back(!((y == 0 && coin[f] && j == 0) ||
                         (y == nl - 1 && f < NF - 1 && !coin[f+1] && j == 3)));
          sd.push_back(24'($urandom()));
        end
        ln_n.push_back(n); ln_y.push_back(y); ln_l.push_back(L);
      end
    end
    n_tail = sh.size();
    for (int j = 0; j < 14; j++) begin sh.push_back(j >= 1); sv.push_back(1); sd.push_back(24'($urandom())); end

    // Scoreboard: captured line c = y - VS lands at (c*BLL) mod RAMW; pixel k of
    // a line whose hsync fell at tick n is sampled at n+2+k and written out then.
    foreach (ln_n[i]) begin
      int c;
      c = ln_y[i] - VS;
      if (c >= 0 && c < VL) begin
        for (int k = HS; k < HS + BLL && k < ln_l[i]; k++) begin
          wr_t w;
          w.t = ln_n[i] + 2 + k;
          w.a = AW'((c * BLL) % RAMW + (k - HS));
          w.d = sd[ln_n[i] + 2 + k];
          exp_wr.push_back(w);
        end
        if (c == TL) exp_tr.push_back(ln_n[i] + ln_l[i] + 1);
      end
    end

    ph0 = stamp; rec = 1;
    foreach (sh[i]) tick(sh[i], sv[i], sd[i]);
    rec = 0;
    chk("rand_locked", 64'(locked), 64'd1);
    chk("rand_wr_count", 64'(got_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      chk($sformatf("rand_wr_t[%0d]", i), 64'(got_wr[i].t), 64'(exp_wr[i].t));
      chk($sformatf("rand_wr_a[%0d]", i), 64'(got_wr[i].a), 64'(exp_wr[i].a));
      chk($sformatf("rand_wr_d[%0d]", i), 64'(got_wr[i].d), 64'(exp_wr[i].d));
    end
    chk("trig_count", 64'(got_tr.size()), 64'(NF));
    for (int i = 0; i < exp_tr.size() && i < got_tr.size(); i++)
      chk($sformatf("trig_t[%0d]", i), 64'(got_tr[i]), 64'(exp_tr[i]));

    // Lost hsync: counterX hits 4095 about 4096 cycles after the last fall.
    drop = -1; wcnt = 0;
    for (int i = 0; i < 4100; i++) begin
      tick(1, 1, 24'($urandom()));
      if (wren) wcnt++;
      if (!locked && drop < 0) drop = sh.size() + i - n_tail;
    end
    chk("lost_drop_ok", 64'(drop == 4096 || drop == 4097), 64'd1);
    chk("lost_no_writes", 64'(wcnt), 64'd0);

    tick(1, 0, 0); tick(1, 1, 0); tick(1, 1, 0); tick(0, 1, 0);
    for (int j = 1; j <= 5; j++) begin
      dd = 24'($urandom());
      tick(1, 1, dd);
      if (j == 3) chk("relock_pre_wren", 64'(wren), 64'd0);
      if (j == 4) begin
        chk("relock_wren", 64'(wren), 64'd1);
        chk("relock_addr", 64'(wraddr), 64'd0);
        chk("relock_data", 64'(wrdata), 64'(dd));
      end
    end

    // Async reset mid-line: outputs clear without any clock edge.
    chk("pre_reset_wren", 64'(wren), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset("async");
    @(posedge clock); #1; @(posedge clock); #1 reset_n = 1'b1;
    wcnt = 0;
    for (int l = 0; l < 3; l++)
      for (int j = 0; j < 10; j++) begin
        tick(j >= 1, 1, 24'($urandom()));
        if (wren || locked) wcnt++;
      end
    chk("post_reset_idle", 64'(wcnt), 64'd0);
    tick(1, 0, 0); tick(1, 1, 0); tick(1, 1, 0); tick(0, 1, 0);
    for (int j = 1; j <= 4; j++) begin
      dd = 24'($urandom());
      tick(1, 1, dd);
    end
    chk("reset_relock_wren", 64'(wren), 64'd1);
    chk("reset_relock_addr", 64'(wraddr), 64'd0);
    chk("reset_relock_data", 64'(wrdata), 64'(dd));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
